// File: rtl/instr_loader.sv
// Byte-stream program loader: length-prefixed image -> sequential instruction memory writes.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
   parameter int unsigned A = 10,
   parameter int unsigned W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   byte_in,
   input  logic         byte_valid,
   output logic         byte_ready,
   output logic         wr_en,
   output logic [A-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [A:0]   words_loaded
);

   localparam int unsigned CAP     = 2 ** A;
   localparam int unsigned HI_BITS = W - 8;
   // High-byte bits that do not fit in the instruction word
   localparam logic [7:0]  HI_BAD  = 8'(16'h00FF << HI_BITS);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CHK, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_DONE, S_ERR
   } state_t;
`endif

   state_t         state, state_nxt;
   logic [15:0]    len_q, len_nxt;
   logic [7:0]     lo_q, lo_nxt;
   logic [W-1:0]   data_nxt;
   logic [A-1:0]   addr_nxt;
   logic [A:0]     words_nxt;
   logic           ready_nxt, busy_nxt, done_nxt, error_nxt, wr_en_nxt;
   logic           xfer;
   logic [15:0]    full_len;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     csum_q, csum_nxt;
`endif

   assign xfer     = byte_valid && byte_ready;
   assign full_len = {byte_in, len_q[7:0]};

   // Next-state and next-register values
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      lo_nxt    = lo_q;
      data_nxt  = wr_data;
      addr_nxt  = wr_addr;
      words_nxt = words_loaded;
`ifdef LOADER_CHECKSUM_EN
      csum_nxt  = csum_q;
`endif
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nxt = S_LEN_LO;
               addr_nxt  = '0;
               words_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
               csum_nxt  = '0;
`endif
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_nxt   = {len_q[15:8], byte_in};
               state_nxt = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_nxt = full_len;
               if (full_len == 16'd0 || 32'(full_len) > CAP) state_nxt = S_ERR;
               else                                           state_nxt = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (xfer) begin
               lo_nxt    = byte_in;
               state_nxt = S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
               csum_nxt  = csum_q ^ byte_in;
`endif
            end
         end
         S_DATA_HI: begin
            if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
               csum_nxt = csum_q ^ byte_in;
`endif
               if ((byte_in & HI_BAD) != 8'd0) begin
                  state_nxt = S_ERR;
               end else begin
                  data_nxt  = W'({byte_in, lo_q});
                  state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            words_nxt = words_loaded + (A+1)'(1);
            if (32'(words_nxt) == 32'(len_q)) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = S_CHK;
`else
               state_nxt = S_DONE;
`endif
            end else begin
               addr_nxt  = wr_addr + A'(1);
               state_nxt = S_DATA_LO;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) state_nxt = (byte_in == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase

      // Outputs are registered decodes of the state being entered
      ready_nxt = 1'b0;
      case (state_nxt)
         S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: ready_nxt = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         S_CHK: ready_nxt = 1'b1;
`endif
         default: ready_nxt = 1'b0;
      endcase
      busy_nxt  = !(state_nxt == S_IDLE || state_nxt == S_DONE || state_nxt == S_ERR);
      done_nxt  = (state_nxt == S_DONE);
      error_nxt = (state_nxt == S_ERR);
      wr_en_nxt = (state_nxt == S_WRITE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         len_q        <= '0;
         lo_q         <= '0;
         wr_data      <= '0;
         wr_addr      <= '0;
         words_loaded <= '0;
         byte_ready   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         wr_en        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state        <= state_nxt;
         len_q        <= len_nxt;
         lo_q         <= lo_nxt;
         wr_data      <= data_nxt;
         wr_addr      <= addr_nxt;
         words_loaded <= words_nxt;
         byte_ready   <= ready_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         error        <= error_nxt;
         wr_en        <= wr_en_nxt;
`ifdef LOADER_CHECKSUM_EN
         csum_q       <= csum_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: hand vectors, corner sequences and random images vs a reference model.
module tb_instr_loader;

   localparam int unsigned A = 10;
   localparam int unsigned W = 9;
   localparam int CAP    = 1 << A;
   localparam int BUDGET = 20000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [7:0]   byte_in = 8'd0;
   logic         byte_valid = 1'b0;
   logic         byte_ready;
   logic         wr_en;
   logic [A-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic         busy, done, error;
   logic [A:0]   words_loaded;

   instr_loader #(.A(A), .W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [95:0] b;
      int          n;
      bit          gaps;
      bit          mid;
      bit          exp_done;
      bit          exp_err;
      int          exp_words;
      int          exp_nwr;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] stream[$];
   int         got_addr[$], got_data[$], exp_addr[$], exp_data[$];
   bit         exp_done, exp_err;
   int         exp_words;
   int         checks = 0;
   int         failures = 0;

   task automatic check(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   function automatic void add_vec(input logic [95:0] b, input int n, input bit gaps, input bit mid,
                                   input bit d, input bit e, input int words, input int nwr);
      vec_t v;
      v.b = b; v.n = n; v.gaps = gaps; v.mid = mid;
      v.exp_done = d; v.exp_err = e; v.exp_words = words; v.exp_nwr = nwr;
      vecs.push_back(v);
   endfunction

   // Reference: interpret the image by the loader's rules
   task automatic model();
      int len, lo, hi, chk;
      exp_addr.delete(); exp_data.delete();
      exp_done = 0; exp_err = 0; exp_words = 0; chk = 0;
      len = int'(stream[0]) + 256 * int'(stream[1]);
      if (len == 0 || len > CAP) begin
         exp_err = 1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         lo = int'(stream[2 + 2*i]);
         hi = int'(stream[3 + 2*i]);
         chk = chk ^ lo ^ hi;
         if (hi >= (1 << (W - 8))) begin
            exp_err = 1;
            return;
         end
         exp_addr.push_back(i);
         exp_data.push_back((hi * 256 + lo) % (1 << W));
         exp_words++;
      end
`ifdef LOADER_CHECKSUM_EN
      if (int'(stream[2 + 2*len]) != chk) exp_err = 1;
      else                                exp_done = 1;
`else
      exp_done = 1;
`endif
   endtask

   // Feed the stream with optional gaps; optionally pulse start while busy and on every WRITE
   task automatic run_stream(input bit gaps, input bit mid, input int abort_addr, output bit aborted);
      int idx = 0;
      int cyc = 0;
      bit fin = 0;
      aborted = 0;
      got_addr.delete(); got_data.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!fin && cyc < BUDGET) begin
         if (wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            if (int'(wr_addr) == abort_addr) begin
               reset = 1'b1;
               #1;
               check("abort_wr_en", int'(wr_en), 0);
               check("abort_busy", int'(busy), 0);
               check("abort_words", int'(words_loaded), 0);
               aborted = 1;
               fin = 1;
            end
         end
         if (!fin) begin
            if (!busy) begin
               fin = 1;
            end else begin
               start = mid && (wr_en || idx == 3);
               if (idx < stream.size()) begin
                  byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                  byte_in    = stream[idx];
               end else begin
                  byte_valid = 1'b0;
               end
               if (byte_valid && byte_ready) idx++;
               @(negedge clk);
               cyc++;
            end
         end
      end
      byte_valid = 1'b0;
      start = 1'b0;
      if (!fin) check("timeout", cyc, -1);
   endtask

   task automatic verify(input string nm);
      check({nm, "_nwr"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
         check({nm, "_addr"}, got_addr[i], exp_addr[i]);
         check({nm, "_data"}, got_data[i], exp_data[i]);
      end
      check({nm, "_done"}, int'(done), int'(exp_done));
      check({nm, "_error"}, int'(error), int'(exp_err));
      check({nm, "_words"}, int'(words_loaded), exp_words);
      check({nm, "_busy"}, int'(busy), 0);
      check({nm, "_ready"}, int'(byte_ready), 0);
   endtask

   task automatic gen_random();
      int len;
      logic [7:0] lo, hi, chk;
      stream.delete();
      len = $urandom_range(1, 6);
      stream.push_back(8'(len));
      stream.push_back(8'h00);
      chk = 8'h00;
      for (int i = 0; i < len; i++) begin
         lo = 8'($urandom);
         hi = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'($urandom_range(0, (1 << (W - 8)) - 1));
         stream.push_back(lo);
         stream.push_back(hi);
         chk = chk ^ lo ^ hi;
      end
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(($urandom_range(0, 5) == 0) ? (chk ^ 8'h01) : chk);
`endif
   endtask

   initial begin
      bit ab;
      int v0d[3];
      v0d[0] = 'h012; v0d[1] = 'h134; v0d[2] = 'h0FF;

`ifdef LOADER_CHECKSUM_EN
      add_vec(96'h03_00_12_00_34_01_FF_00_D8, 9, 0, 0, 1, 0, 3, 3);
`else
      add_vec(96'h03_00_12_00_34_01_FF_00,    8, 0, 0, 1, 0, 3, 3);
`endif
      add_vec(96'h00_00,             2, 0, 0, 0, 1, 0, 0);
      add_vec(96'h01_04,             2, 0, 0, 0, 1, 0, 0);
      add_vec(96'h01_00_55_02,       4, 0, 0, 0, 1, 0, 0);
`ifdef LOADER_CHECKSUM_EN
      add_vec(96'h02_00_11_01_22_00_32, 7, 1, 1, 1, 0, 2, 2);
      add_vec(96'h01_00_AA_01_AA,       5, 0, 0, 0, 1, 1, 1);
      add_vec(96'h03_00_12_00_34_01_FF_00_D8, 9, 1, 1, 1, 0, 3, 3);
`else
      add_vec(96'h02_00_11_01_22_00,    6, 1, 1, 1, 0, 2, 2);
      add_vec(96'h01_00_AA_01_AA,       5, 0, 0, 1, 0, 1, 1);
      add_vec(96'h03_00_12_00_34_01_FF_00,    8, 1, 1, 1, 0, 3, 3);
`endif

      // Reset state
      #2;
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      check("rst_ready", int'(byte_ready), 0);
      check("rst_addr", int'(wr_addr), 0);
      check("rst_data", int'(wr_data), 0);
      check("rst_words", int'(words_loaded), 0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);

      // Table vectors
      foreach (vecs[i]) begin
         stream.delete();
         for (int j = 0; j < vecs[i].n; j++) stream.push_back(vecs[i].b[8*(vecs[i].n-1-j) +: 8]);
         model();
         run_stream(vecs[i].gaps, vecs[i].mid, -1, ab);
         verify($sformatf("vec%0d", i));
         check($sformatf("vec%0d_tdone", i), int'(done), int'(vecs[i].exp_done));
         check($sformatf("vec%0d_terr", i), int'(error), int'(vecs[i].exp_err));
         check($sformatf("vec%0d_twords", i), int'(words_loaded), vecs[i].exp_words);
         check($sformatf("vec%0d_tnwr", i), got_addr.size(), vecs[i].exp_nwr);
         if (i == 0 || i == 6) begin
            for (int k = 0; k < 3; k++)
               check($sformatf("vec%0d_hdata%0d", i, k), (k < got_data.size()) ? got_data[k] : -1, v0d[k]);
         end
      end

      // Reset during WRITE of word 1 of 4, then a clean reload from address 0
      stream.delete();
      stream.push_back(8'h04); stream.push_back(8'h00);
      for (int i = 0; i < 4; i++) begin stream.push_back(8'(16 * i + 5)); stream.push_back(8'h01); end
`ifdef LOADER_CHECKSUM_EN
      stream.push_back(8'h05 ^ 8'h15 ^ 8'h25 ^ 8'h35);
`endif
      run_stream(0, 0, 1, ab);
      check("abort_hit", int'(ab), 1);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      model();
      run_stream(1, 0, -1, ab);
      verify("reload");

      // byte_valid held low: loader waits in the length phase
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (40) @(negedge clk);
      check("hold_busy", int'(busy), 1);
      check("hold_ready", int'(byte_ready), 1);
      check("hold_wr_en", int'(wr_en), 0);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);

      // Full capacity image: addresses 0..CAP-1, no wrap
      stream.delete();
      stream.push_back(8'(CAP % 256)); stream.push_back(8'(CAP / 256));
      begin
         logic [7:0] c = 8'h00;
         for (int i = 0; i < CAP; i++) begin
            stream.push_back(8'(i)); stream.push_back(8'(i / 256) & 8'h01);
            c = c ^ 8'(i) ^ (8'(i / 256) & 8'h01);
         end
`ifdef LOADER_CHECKSUM_EN
         stream.push_back(c);
`endif
      end
      model();
      run_stream(0, 0, -1, ab);
      verify("full");
      check("full_words", int'(words_loaded), CAP);

      // Random images
      for (int r = 0; r < 40; r++) begin
         gen_random();
         model();
         run_stream(r[0], r[1], -1, ab);
         verify($sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
